// File: rtl/loop_arb_pkg.sv
// Shared types and helpers for the arbiter request stage.
// Contents: MAX_REQ / MAX_IDX_W limits, idx_w() index width, onehot_ok()
// zero-or-one-hot check, onehot2idx() one-hot to binary index.
package loop_arb_pkg;

  localparam int unsigned MAX_REQ   = 32;
  localparam int unsigned MAX_IDX_W = 5;

  // Channel index width; at least one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // True when v has no bit or exactly one bit set.
  function automatic logic onehot_ok(input logic [MAX_REQ-1:0] v);
    return (v & (v - MAX_REQ'(1))) == '0;
  endfunction

  // Binary index of a one-hot vector (zero vector maps to 0).
  function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_REQ-1:0] v);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (v[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_req_stage_if.sv
// Bus bundle between the request stage, its channels, the arbiter and the
// shared-resource output.
// slave  : request-stage side (drives in_ready, arb_req/arb_en, out_*, err, starve)
// master : environment side (drives in_valid/in_data, arb_gnt, out_ready)
interface arb_req_stage_if
  import loop_arb_pkg::*;
#(
  parameter int unsigned REQ_NUM = 7,
  parameter int unsigned DATA_W  = 32
);
  localparam int unsigned IDX_W = idx_w(REQ_NUM);

  logic [REQ_NUM-1:0]        in_valid;
  logic [REQ_NUM*DATA_W-1:0] in_data;
  logic [REQ_NUM-1:0]        in_ready;
  logic [REQ_NUM-1:0]        arb_req;
  logic                      arb_en;
  logic [REQ_NUM-1:0]        arb_gnt;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [IDX_W-1:0]          out_src;
  logic                      err;
  logic [REQ_NUM-1:0]        starve;

  modport slave (
    input  in_valid, in_data, arb_gnt, out_ready,
    output in_ready, arb_req, arb_en, out_valid, out_data, out_src, err, starve
  );

  modport master (
    output in_valid, in_data, arb_gnt, out_ready,
    input  in_ready, arb_req, arb_en, out_valid, out_data, out_src, err, starve
  );

endinterface

// File: rtl/arb_req_slot.sv
// One-entry holding slot for a single request channel.
// Ports: clk, rst_n, in_valid_i/in_data_i (channel request), take_i (grant
// consumed this cycle), in_ready_o, occ_o, data_o, starve_o.
// Optional ARB_STAGE_WDOG_EN: saturating wait counter driving starve_o.
module arb_req_slot #(
  parameter int unsigned DATA_W = 32
`ifdef ARB_STAGE_WDOG_EN
  , parameter int unsigned STARVE_LIM = 64
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              take_i,
  output logic              in_ready_o,
  output logic              occ_o,
  output logic [DATA_W-1:0] data_o,
  output logic              starve_o
);

  logic              occ_q, occ_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              load;

  // A slot being drained this cycle may be refilled in the same cycle.
  assign in_ready_o = ~occ_q | take_i;
  assign load       = in_valid_i & in_ready_o;

  always_comb begin
    occ_d  = occ_q;
    data_d = data_q;
    if (load) begin
      occ_d  = 1'b1;
      data_d = in_data_i;
    end else if (take_i) begin
      occ_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 1'b0;
      data_q <= '0;
    end else begin
      occ_q  <= occ_d;
      data_q <= data_d;
    end
  end

  assign occ_o  = occ_q;
  assign data_o = data_q;

`ifdef ARB_STAGE_WDOG_EN
  localparam int unsigned      CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM   = CNT_W'(STARVE_LIM);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts cycles spent waiting; saturates at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (!occ_q || take_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIM) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign starve_o = (cnt_q == LIM);
`else
  assign starve_o = 1'b0;
`endif

endmodule

// File: rtl/arb_req_stage.sv
// Front end of the round-robin arbiter: per-channel holding slots, req gating,
// grant checking and a registered valid/ready output stage.
// Ports: clk, rst_n, bus (arb_req_stage_if.slave: in_valid/in_data/in_ready,
// arb_req/arb_en/arb_gnt, out_valid/out_ready/out_data/out_src, err, starve).
// Optional feature macro: ARB_STAGE_WDOG_EN (per-slot starvation watchdog).
module arb_req_stage
  import loop_arb_pkg::*;
#(
  parameter int unsigned REQ_NUM    = 7,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_LIM = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  arb_req_stage_if.slave   bus
);

  localparam int unsigned IDX_W = idx_w(REQ_NUM);

  if (REQ_NUM < 2 || REQ_NUM > MAX_REQ || STARVE_LIM < 1) begin : g_bad_param
    $error("arb_req_stage: illegal parameter value");
  end

  logic [REQ_NUM-1:0] occ;
  logic [REQ_NUM-1:0] take;
  logic [REQ_NUM-1:0] in_ready_w;
  logic [REQ_NUM-1:0] starve_w;
  logic [DATA_W-1:0]  slot_data [REQ_NUM];
  logic               load_ok;
  logic               gnt_bad;
  logic [DATA_W-1:0]  sel_data;

  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [IDX_W-1:0]   out_src_q, out_src_d;
  logic               err_q, err_d;

  // Holding slots, one per channel.
  for (genvar i = 0; i < REQ_NUM; i++) begin : g_slot
    arb_req_slot #(
      .DATA_W     (DATA_W)
`ifdef ARB_STAGE_WDOG_EN
      , .STARVE_LIM (STARVE_LIM)
`endif
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid_i (bus.in_valid[i]),
      .in_data_i  (bus.in_data[i*DATA_W +: DATA_W]),
      .take_i     (take[i]),
      .in_ready_o (in_ready_w[i]),
      .occ_o      (occ[i]),
      .data_o     (slot_data[i]),
      .starve_o   (starve_w[i])
    );
  end

  // Req is withheld under backpressure so the arbiter's priority only rotates
  // on cycles where its grant is actually consumed.
  assign load_ok     = ~out_valid_q | bus.out_ready;
  assign bus.arb_req = occ & {REQ_NUM{load_ok}};
  assign bus.arb_en  = load_ok & (|occ);

  // Grant check and consumption; an illegal grant consumes nothing.
  always_comb begin
    gnt_bad = !onehot_ok(MAX_REQ'(bus.arb_gnt))
            || ((bus.arb_gnt != '0) && (bus.arb_req == '0))
            || ((bus.arb_gnt & ~occ) != '0);
    take    = gnt_bad ? '0 : (bus.arb_gnt & bus.arb_req);
  end

  // Output stage next state: load on a take, drain on out_ready, else hold.
  always_comb begin
    sel_data    = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    err_d       = err_q | gnt_bad;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (take[i]) sel_data = sel_data | slot_data[i];
    end
    if (|take) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_src_d   = IDX_W'(onehot2idx(MAX_REQ'(take)));
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.starve    = starve_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_arb_req_stage.sv
// Self-checking bench for arb_req_stage with a reference round-robin arbiter.
module tb_arb_req_stage;
  import loop_arb_pkg::*;

  localparam int unsigned N  = 7;
  localparam int unsigned DW = 32;
`ifdef ARB_STAGE_WDOG_EN
  localparam int unsigned LIM = 4;
  localparam logic [N-1:0] EXP_STARVE5 = 7'h20;
`else
  localparam int unsigned LIM = 64;
  localparam logic [N-1:0] EXP_STARVE5 = 7'h00;
`endif

  typedef struct packed {
    logic [2:0]    src;
    logic [DW-1:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  arb_req_stage_if #(.REQ_NUM(N), .DATA_W(DW)) bus ();

  arb_req_stage #(.REQ_NUM(N), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  // Reference round-robin arbiter with an override for illegal grants.
  logic         force_en;
  logic [N-1:0] force_val;
  logic [N-1:0] gnt_m;
  int           gnt_idx;
  int           last_q;

  always_comb begin
    gnt_m   = '0;
    gnt_idx = 0;
    for (int k = 1; k <= N; k++) begin
      if (gnt_m == '0 && bus.arb_req[(last_q + k) % N]) begin
        gnt_m[(last_q + k) % N] = 1'b1;
        gnt_idx = (last_q + k) % N;
      end
    end
  end

  assign bus.arb_gnt = force_en ? force_val : gnt_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= N - 1;
    else if (!force_en && bus.arb_en && gnt_m != '0) last_q <= gnt_idx;
  end

  // Scoreboard: every accepted output must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got src=%0d data=%h, required no output", bus.out_src, bus.out_data);
      end else begin
        mon_e = sb_q.pop_front();
        if (bus.out_src !== mon_e.src || bus.out_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL sb_output: got src=%0d data=%h, required src=%0d data=%h",
                   bus.out_src, bus.out_data, mon_e.src, mon_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    bus.in_data[i*DW +: DW] = v;
  endtask

  task automatic push(input int i, input logic [DW-1:0] v);
    exp_t e;
    e.src  = 3'(i);
    e.data = v;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    force_en      = 1'b0;
    force_val     = '0;
    sb_q.delete();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Bounded wait for all expected outputs to leave the DUT.
  task automatic drain(input string name);
    int k;
    k = 0;
    bus.out_ready = 1'b1;
    while (sb_q.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d outputs outstanding, required 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_chk++;
    if ({bus.out_valid, bus.out_src, bus.err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got valid=%b src=%0d err=%b, required 0", bus.out_valid, bus.out_src, bus.err);
    end
    n_chk++;
    if (bus.out_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h, required 0", bus.out_data);
    end
    n_chk++;
    if (bus.in_ready !== 7'h7F || bus.starve !== 7'h00) begin
      n_fail++; $display("FAIL reset_ready: got in_ready=%h starve=%h, required 7f/00", bus.in_ready, bus.starve);
    end
    n_chk++;
    if (bus.arb_req !== 7'h00 || bus.arb_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_req: got req=%h en=%b, required 00/0", bus.arb_req, bus.arb_en);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.out_ready = 1'b1;
    set_data(3, 32'hA5);
    bus.in_valid = 7'h08;
    push(3, 32'hA5);
    tick();
    bus.in_valid = '0;
    @(negedge clk);
    n_chk++;
    if (bus.arb_req !== 7'h08 || bus.arb_en !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_req: got req=%h en=%b valid=%b, required 08/1/0", bus.arb_req, bus.arb_en, bus.out_valid);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA5 || bus.out_src !== 3'd3) begin
      n_fail++;
      $display("FAIL single_out: got valid=%b data=%h src=%0d, required 1/a5/3", bus.out_valid, bus.out_data, bus.out_src);
    end
    drain("single");
  endtask

  task automatic test_all_channels();
    logic [7:0] seen;
    int vcnt;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_data(i, 32'(i));
      push(i, 32'(i));
    end
    bus.in_valid = 7'h7F;
    tick();
    bus.in_valid = '0;
    @(negedge clk);
    n_chk++;
    if (bus.arb_req !== 7'h7F) begin
      n_fail++; $display("FAIL all_req: got %h, required 7f", bus.arb_req);
    end
    seen = '0;
    vcnt = 0;
    repeat (N) begin
      @(negedge clk);
      if (bus.out_valid) begin
        vcnt++;
        seen[bus.out_src] = 1'b1;
      end
    end
    n_chk++;
    if (vcnt != N || seen !== 8'h7F) begin
      n_fail++; $display("FAIL all_burst: got %0d valid cycles srcs=%h, required 7/7f", vcnt, seen);
    end
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.arb_en !== 1'b0) begin
      n_fail++; $display("FAIL all_idle: got valid=%b en=%b, required 0/0", bus.out_valid, bus.arb_en);
    end
    drain("all");
  endtask

  task automatic test_backpressure();
    do_reset();
    set_data(0, 32'h30);
    set_data(1, 32'h31);
    set_data(4, 32'h34);
    push(0, 32'h30);
    push(1, 32'h31);
    push(4, 32'h34);
    bus.in_valid = 7'h13;
    tick();
    bus.in_valid = '0;
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++;
      if ({bus.arb_req, bus.arb_en, bus.out_valid, bus.out_data} !== {7'h00, 1'b0, 1'b1, 32'h30}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got req=%h en=%b valid=%b data=%h, required 00/0/1/30",
                 c, bus.arb_req, bus.arb_en, bus.out_valid, bus.out_data);
      end
    end
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.arb_req !== 7'h12) begin
      n_fail++; $display("FAIL bp_release: got req=%h, required 12", bus.arb_req);
    end
    drain("bp");
  endtask

  task automatic test_refill();
    do_reset();
    bus.out_ready = 1'b1;
    set_data(2, 32'h11);
    bus.in_valid = 7'h04;
    push(2, 32'h11);
    tick();
    set_data(2, 32'h55);
    push(2, 32'h55);
    @(negedge clk);
    n_chk++;
    if (bus.in_ready[2] !== 1'b1 || bus.arb_req !== 7'h04) begin
      n_fail++; $display("FAIL refill_ready: got in_ready=%h req=%h, required bit2=1/04", bus.in_ready, bus.arb_req);
    end
    tick();
    bus.in_valid = '0;
    @(negedge clk);
    n_chk++;
    if (bus.arb_req !== 7'h04 || bus.out_data !== 32'h11) begin
      n_fail++; $display("FAIL refill_occ: got req=%h data=%h, required 04/11", bus.arb_req, bus.out_data);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h55 || bus.out_src !== 3'd2) begin
      n_fail++;
      $display("FAIL refill_out: got valid=%b data=%h src=%0d, required 1/55/2", bus.out_valid, bus.out_data, bus.out_src);
    end
    drain("refill");
  endtask

  task automatic test_err_and_reset();
    do_reset();
    bus.out_ready = 1'b1;
    force_en  = 1'b1;
    force_val = '0;
    set_data(2, 32'h52);
    set_data(3, 32'h53);
    bus.in_valid = 7'h0C;
    tick();
    bus.in_valid = '0;
    force_val = 7'h0C;
    tick();
    @(negedge clk);
    n_chk++;
    if (bus.err !== 1'b1 || bus.out_valid !== 1'b0 || bus.arb_req !== 7'h0C) begin
      n_fail++;
      $display("FAIL err_twohot: got err=%b valid=%b req=%h, required 1/0/0c", bus.err, bus.out_valid, bus.arb_req);
    end
    force_val = '0;
    tick();
    @(negedge clk);
    n_chk++;
    if (bus.err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got %b, required 1", bus.err);
    end
    push(2, 32'h52);
    push(3, 32'h53);
    tick();
    force_en = 1'b0;
    tick();
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b1 || bus.out_src !== 3'd2) begin
      n_fail++; $display("FAIL err_resume: got valid=%b src=%0d, required 1/2", bus.out_valid, bus.out_src);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.out_valid, bus.out_src, bus.err, bus.arb_en} !== 6'b0 || bus.out_data !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b src=%0d err=%b en=%b data=%h, required all 0",
               bus.out_valid, bus.out_src, bus.err, bus.arb_en, bus.out_data);
    end
    n_chk++;
    if (bus.arb_req !== 7'h00 || bus.in_ready !== 7'h7F) begin
      n_fail++; $display("FAIL async_slots: got req=%h in_ready=%h, required 00/7f", bus.arb_req, bus.in_ready);
    end
    sb_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_discard: got valid=%b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_starve();
    do_reset();
    set_data(0, 32'h60);
    set_data(5, 32'h65);
    push(0, 32'h60);
    push(5, 32'h65);
    bus.in_valid = 7'h21;
    tick();
    bus.in_valid = '0;
    repeat (3) tick();
    @(negedge clk);
    n_chk++;
    if (bus.starve !== 7'h00) begin
      n_fail++; $display("FAIL starve_early: got %h, required 00", bus.starve);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if (bus.starve !== EXP_STARVE5) begin
      n_fail++; $display("FAIL starve_set: got %h, required %h", bus.starve, EXP_STARVE5);
    end
    tick();
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.starve !== EXP_STARVE5) begin
      n_fail++; $display("FAIL starve_sat: got %h, required %h", bus.starve, EXP_STARVE5);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if (bus.starve !== 7'h00) begin
      n_fail++; $display("FAIL starve_clear: got %h, required 00", bus.starve);
    end
    drain("starve");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    force_en      = 1'b0;
    force_val     = '0;
    test_reset();
    test_single();
    test_all_channels();
    test_backpressure();
    test_refill();
    test_err_and_reset();
    test_starve();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
